cpu64_l1_evict_reader: RTL and testbench

CPU64_L1_EVICT_READER -- requirements
Module: cpu64_l1_evict_reader

---
 rtl/cpu64_l1_evict_reader.sv | 207 ++++++++++++++++++++
 tb/tb_cpu64_l1_evict_reader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu64_l1_evict_reader.sv
// L1 eviction/probe reader: walks one cache line out of the data array onto the
// TL-C C channel (Release/ProbeAck, with or without data), then rewrites tag/state.
module cpu64_l1_evict_reader #(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 53,
  localparam int AW     = TAG_W + INDEX_W + 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  // request
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_release_i,
  input  logic               req_dirty_i,
  input  logic [INDEX_W-1:0] req_index_i,
  input  logic [2:0]         req_way_i,
  input  logic [TAG_W-1:0]   req_tag_i,
  input  logic [2:0]         req_param_i,
  input  logic [1:0]         req_new_state_i,
  // data/tag array
  output logic [INDEX_W-1:0] arr_index_o,
  output logic [2:0]         arr_way_o,
  output logic [2:0]         arr_word_o,
  input  logic [63:0]        arr_rdata_i,
  output logic               arr_we_o,
  output logic [7:0]         arr_be_o,
  output logic [TAG_W-1:0]   arr_tag_o,
  output logic [1:0]         arr_state_o,
  // C channel
  output logic               c_valid_o,
  input  logic               c_ready_i,
  output logic [2:0]         c_opcode_o,
  output logic [2:0]         c_param_o,
  output logic [2:0]         c_size_o,
  output logic [AW-1:0]      c_address_o,
  output logic [63:0]        c_data_o,
  output logic               c_last_o,
  output logic               done_o
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready_o high
  // FETCH | read word 0 of the line into the data register
  // SEND  | present beats on C; next word is pre-addressed for zero-bubble capture
  // UPD   | write latched tag/state back, data bytes untouched
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_UPD   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic               release_q, release_d;
  logic               dirty_q, dirty_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [2:0]         way_q, way_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [2:0]         param_q, param_d;
  logic [1:0]         new_state_q, new_state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [63:0]        data_q, data_d;

  logic accept;
  logic beat_fire;
  logic last_beat;

  assign accept    = (state_q == S_IDLE) && req_valid_i;
  assign beat_fire = (state_q == S_SEND) && c_ready_i;
  assign last_beat = !dirty_q || (cnt_q == 3'd7);

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid_i) state_d = req_dirty_i ? S_FETCH : S_SEND;
      S_FETCH: state_d = S_SEND;
      S_SEND:  if (c_ready_i && last_beat) state_d = S_UPD;
      S_UPD:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // request latch, beat counter and data register
  always_comb begin
    release_d   = release_q;
    dirty_d     = dirty_q;
    index_d     = index_q;
    way_d       = way_q;
    tag_d       = tag_q;
    param_d     = param_q;
    new_state_d = new_state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    if (accept) begin
      release_d   = req_release_i;
      dirty_d     = req_dirty_i;
      index_d     = req_index_i;
      way_d       = req_way_i;
      tag_d       = req_tag_i;
      param_d     = req_param_i;
      new_state_d = req_new_state_i;
      cnt_d       = 3'd0;
      data_d      = 64'd0;
    end else if (state_q == S_FETCH) begin
      cnt_d  = 3'd0;
      data_d = arr_rdata_i;
    end else if (beat_fire && !last_beat) begin
      cnt_d  = cnt_q + 3'd1;
      data_d = arr_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      release_q   <= 1'b0;
      dirty_q     <= 1'b0;
      index_q     <= '0;
      way_q       <= 3'd0;
      tag_q       <= '0;
      param_q     <= 3'd0;
      new_state_q <= 2'd0;
      cnt_q       <= 3'd0;
      data_q      <= 64'd0;
    end else begin
      release_q   <= release_d;
      dirty_q     <= dirty_d;
      index_q     <= index_d;
      way_q       <= way_d;
      tag_q       <= tag_d;
      param_q     <= param_d;
      new_state_q <= new_state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
    end
  end

  // outputs; everything is decoded from registered state so C stays stable under stall
  always_comb begin
    req_ready_o = 1'b0;
    arr_index_o = '0;
    arr_way_o   = 3'd0;
    arr_word_o  = 3'd0;
    arr_we_o    = 1'b0;
    arr_be_o    = 8'h00;
    arr_tag_o   = '0;
    arr_state_o = 2'd0;
    c_valid_o   = 1'b0;
    c_opcode_o  = 3'd0;
    c_param_o   = 3'd0;
    c_size_o    = 3'd0;
    c_address_o = '0;
    c_data_o    = 64'd0;
    c_last_o    = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
      end
      S_FETCH: begin
        arr_index_o = index_q;
        arr_way_o   = way_q;
        arr_word_o  = 3'd0;
      end
      S_SEND: begin
        arr_index_o = index_q;
        arr_way_o   = way_q;
        arr_word_o  = cnt_q + 3'd1;
        c_valid_o   = 1'b1;
        c_opcode_o  = {1'b1, release_q, dirty_q};
        c_param_o   = param_q;
        c_size_o    = 3'd6;
        c_address_o = {tag_q, index_q, 6'b0};
        c_data_o    = dirty_q ? data_q : 64'd0;
        c_last_o    = last_beat;
      end
      S_UPD: begin
        arr_index_o = index_q;
        arr_way_o   = way_q;
        arr_we_o    = 1'b1;
        arr_be_o    = 8'h00;
        arr_tag_o   = tag_q;
        arr_state_o = new_state_q;
      end
      S_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        req_ready_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu64_l1_evict_reader.sv
// Randomized bench for cpu64_l1_evict_reader with a transaction-level line/beat model.
module tb_cpu64_l1_evict_reader;
  localparam int IW = 5;
  localparam int TW = 53;
  localparam int AW = TW + IW + 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_release, req_dirty;
  logic [IW-1:0] req_index;
  logic [2:0]    req_way, req_param;
  logic [TW-1:0] req_tag;
  logic [1:0]    req_new_state;
  logic [IW-1:0] arr_index;
  logic [2:0]    arr_way, arr_word;
  logic [63:0]   arr_rdata;
  logic          arr_we;
  logic [7:0]    arr_be;
  logic [TW-1:0] arr_tag;
  logic [1:0]    arr_state;
  logic          c_valid, c_ready, c_last, done;
  logic [2:0]    c_opcode, c_param, c_size;
  logic [AW-1:0] c_address;
  logic [63:0]   c_data;

  always #5 clk = ~clk;

  cpu64_l1_evict_reader #(.INDEX_W(IW), .TAG_W(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_release_i(req_release),
    .req_dirty_i(req_dirty), .req_index_i(req_index), .req_way_i(req_way),
    .req_tag_i(req_tag), .req_param_i(req_param), .req_new_state_i(req_new_state),
    .arr_index_o(arr_index), .arr_way_o(arr_way), .arr_word_o(arr_word),
    .arr_rdata_i(arr_rdata), .arr_we_o(arr_we), .arr_be_o(arr_be),
    .arr_tag_o(arr_tag), .arr_state_o(arr_state),
    .c_valid_o(c_valid), .c_ready_i(c_ready), .c_opcode_o(c_opcode), .c_param_o(c_param),
    .c_size_o(c_size), .c_address_o(c_address), .c_data_o(c_data), .c_last_o(c_last),
    .done_o(done)
  );

  // line data indexed by {way, index, word}
  logic [63:0] mem [0:2047];
  assign arr_rdata = mem[{arr_way, arr_index, arr_word}];

  typedef struct packed {
    logic [2:0]    op;
    logic [2:0]    prm;
    logic [AW-1:0] addr;
    logic [63:0]   data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [2:0]    way;
    logic [TW-1:0] tag;
    logic [1:0]    st;
  } wr_t;

  beat_t exp_beats[$];
  wr_t   exp_wr[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int beats_seen = 0;
  int we_total = 0;
  int last_done_cyc = -1;
  int rdy_mode = 0;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [191:0] c_snap();
    return 192'({c_valid, c_opcode, c_param, c_size, c_address, c_data, c_last});
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    c_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       c_ready = 1'b1;
        1:       c_ready = ~c_ready;
        default: c_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // C-channel / array-write monitor
  logic         stall_q = 1'b0;
  logic [191:0] snap_q;
  initial begin
    beat_t b;
    wr_t   w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) chk("c_hold", c_snap(), snap_q);
        stall_q = c_valid && !c_ready;
        snap_q  = c_snap();
        if (c_valid && arr_we) chk("we_during_send", 192'(1), 192'(0));
        if (c_valid && c_ready) begin
          beats_seen++;
          if (exp_beats.size() == 0) begin
            chk("extra_beat", 192'(1), 192'(0));
          end else begin
            b = exp_beats.pop_front();
            chk("beat_op", 192'(c_opcode), 192'(b.op));
            chk("beat_param", 192'(c_param), 192'(b.prm));
            chk("beat_size", 192'(c_size), 192'(3'd6));
            chk("beat_addr", 192'(c_address), 192'(b.addr));
            chk("beat_data", 192'(c_data), 192'(b.data));
            chk("beat_last", 192'(c_last), 192'(b.last));
          end
        end
        if (arr_we) begin
          we_total++;
          chk("upd_be", 192'(arr_be), 192'(8'h00));
          if (exp_wr.size() == 0) begin
            chk("extra_write", 192'(1), 192'(0));
          end else begin
            w = exp_wr.pop_front();
            chk("upd_fields", 192'({arr_index, arr_way, arr_tag, arr_state}), 192'(w));
          end
        end
        if (done) last_done_cyc = cyc;
      end
    end
  end

  task automatic push_exp(input logic rel, input logic dirty, input logic [IW-1:0] idx,
                          input logic [2:0] way, input logic [TW-1:0] tag,
                          input logic [2:0] prm, input logic [1:0] ns);
    beat_t b;
    wr_t   w;
    b.op   = {1'b1, rel, dirty};
    b.prm  = prm;
    b.addr = {tag, idx, 6'b0};
    if (dirty) begin
      for (int k = 0; k < 8; k++) begin
        b.data = mem[{way, idx, 3'(k)}];
        b.last = (k == 7);
        exp_beats.push_back(b);
      end
    end else begin
      b.data = 64'd0;
      b.last = 1'b1;
      exp_beats.push_back(b);
    end
    w.idx = idx; w.way = way; w.tag = tag; w.st = ns;
    exp_wr.push_back(w);
  endtask

  task automatic drive_req(input logic rel, input logic dirty, input logic [IW-1:0] idx,
                           input logic [2:0] way, input logic [TW-1:0] tag,
                           input logic [2:0] prm, input logic [1:0] ns);
    req_release = rel; req_dirty = dirty; req_index = idx; req_way = way;
    req_tag = tag; req_param = prm; req_new_state = ns; req_valid = 1'b1;
  endtask

  task automatic wait_accept(output int acc);
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin acc = cyc; break; end
    end
    if (acc < 0) chk("accept_timeout", 192'(1), 192'(0));
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin dc = cyc; break; end
    end
    if (dc < 0) chk("done_timeout", 192'(1), 192'(0));
  endtask

  task automatic do_txn(input logic rel, input logic dirty, input logic [IW-1:0] idx,
                        input logic [2:0] way, input logic [TW-1:0] tag,
                        input logic [2:0] prm, input logic [1:0] ns);
    int acc, dc;
    push_exp(rel, dirty, idx, way, tag, prm, ns);
    drive_req(rel, dirty, idx, way, tag, prm, ns);
    wait_accept(acc);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_done(dc);
    if (rdy_mode == 0) chk("latency", 192'(dc - acc), 192'(dirty ? 11 : 3));
    @(negedge clk);
    chk("done_pulse", 192'({done, req_ready}), 192'(2'b01));
    chk("beats_left", 192'(exp_beats.size()), 192'(0));
    chk("writes_left", 192'(exp_wr.size()), 192'(0));
    @(posedge clk); #1;
  endtask

  function automatic logic [TW-1:0] rand_tag();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[TW-1:0];
  endfunction

  initial begin
    int acc1, acc2, dc, b0, b1, w0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_release = 1'b0; req_dirty = 1'b0; req_index = '0;
    req_way = 3'd0; req_tag = '0; req_param = 3'd0; req_new_state = 2'd0;
    for (int i = 0; i < 2048; i++) mem[i] = {$urandom(), $urandom()};
    #2;
    chk("rst_ctrl", 192'({c_valid, c_last, arr_we, done, req_ready}), 192'(5'b00001));
    chk("rst_others", 192'({c_opcode, c_param, c_size, c_address, c_data, arr_be, arr_tag,
                            arr_state, arr_index, arr_way, arr_word}), 192'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // dirty Release, known line contents
    for (int k = 0; k < 8; k++) mem[{3'd3, 5'd5, 3'(k)}] = 64'h1000 + 64'(k);
    do_txn(1'b1, 1'b1, 5'd5, 3'd3, rand_tag(), 3'd0, 2'd1);
    // clean ProbeAck
    do_txn(1'b0, 1'b0, 5'd9, 3'd1, rand_tag(), 3'd1, 2'd2);
    // dirty ProbeAck under 1010 back-pressure
    rdy_mode = 1;
    do_txn(1'b0, 1'b1, 5'd17, 3'd6, rand_tag(), 3'd2, 2'd0);
    // max index with all-ones tag
    rdy_mode = 0;
    do_txn(1'b1, 1'b1, 5'd31, 3'd7, {TW{1'b1}}, 3'd5, 2'd3);

    // back-to-back with req_valid held
    push_exp(1'b1, 1'b1, 5'd2, 3'd0, rand_tag(), 3'd0, 2'd1);
    drive_req(exp_wr[0].tag[0], 1'b1, 5'd2, 3'd0, exp_wr[0].tag, 3'd0, 2'd1);
    req_release = 1'b1;
    wait_accept(acc1);
    @(posedge clk); #1;
    push_exp(1'b0, 1'b0, 5'd3, 3'd4, rand_tag(), 3'd3, 2'd2);
    drive_req(1'b0, 1'b0, 5'd3, 3'd4, exp_wr[1].tag, 3'd3, 2'd2);
    wait_accept(acc2);
    chk("b2b_first_done", 192'(last_done_cyc - acc1), 192'(11));
    chk("b2b_accept_after_done", 192'(acc2 - last_done_cyc), 192'(1));
    @(posedge clk); #1 req_valid = 1'b0;
    wait_done(dc);
    chk("b2b_second_latency", 192'(dc - acc2), 192'(3));
    @(posedge clk); #1;
    chk("b2b_beats_left", 192'(exp_beats.size()), 192'(0));

    // randomized traffic and back-pressure
    for (int t = 0; t < 25; t++) begin
      rdy_mode = int'($urandom_range(0, 2));
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             3'($urandom_range(0, 7)), rand_tag(), 3'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)));
    end

    // reset after the third beat
    rdy_mode = 0;
    push_exp(1'b1, 1'b1, 5'd12, 3'd2, rand_tag(), 3'd0, 2'd1);
    drive_req(1'b1, 1'b1, 5'd12, 3'd2, exp_wr[0].tag, 3'd0, 2'd1);
    wait_accept(acc1);
    @(posedge clk); #1 req_valid = 1'b0;
    b0 = beats_seen;
    for (int i = 0; i < 50 && beats_seen < b0 + 3; i++) @(negedge clk);
    chk("rst_pre_beats", 192'(beats_seen - b0), 192'(3));
    w0 = we_total;
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk("rst_mid_outputs", 192'({c_valid, c_last, arr_we, done}), 192'(0));
    exp_beats.delete();
    exp_wr.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    b1 = beats_seen;
    @(negedge clk);
    chk("rst_ready", 192'(req_ready), 192'(1));
    repeat (12) @(negedge clk);
    chk("rst_no_beats", 192'(beats_seen - b1), 192'(0));
    chk("rst_no_write", 192'(we_total - w0), 192'(0));
    @(posedge clk); #1;
    do_txn(1'b0, 1'b1, 5'd1, 3'd5, rand_tag(), 3'd4, 2'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
